// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core instruction sequencer: inst field positions,
// the idle packet, FSM state encoding and a named-field view of a packet.
package core_ctrl_pkg;

    localparam int INST_W    = 34;
    localparam int A_FIELD_W = 11;

    localparam int ACC_BIT      = 33;
    localparam int CEN_PMEM_BIT = 32;
    localparam int WEN_PMEM_BIT = 31;
    localparam int A_PMEM_LSB   = 20;
    localparam int CEN_XMEM_BIT = 19;
    localparam int WEN_XMEM_BIT = 18;
    localparam int A_XMEM_LSB   = 7;
    localparam int OFIFO_RD_BIT = 6;
    localparam int IFIFO_WR_BIT = 5;
    localparam int IFIFO_RD_BIT = 4;
    localparam int L0_RD_BIT    = 3;
    localparam int L0_WR_BIT    = 2;
    localparam int EXECUTE_BIT  = 1;
    localparam int LOAD_BIT     = 0;

    localparam logic [INST_W-1:0] IDLE_INST = 34'h1800C0000;

    typedef enum logic [3:0] {
        IDLE, W_WR, A_WR, W_L0, W_LOAD, A_L0, EXEC, DRAIN, DONE
    } state_t;

    typedef struct packed {
        logic                 acc;
        logic                 cen_pmem;
        logic                 wen_pmem;
        logic [A_FIELD_W-1:0] a_pmem;
        logic                 cen_xmem;
        logic                 wen_xmem;
        logic [A_FIELD_W-1:0] a_xmem;
        logic                 ofifo_rd;
        logic                 ififo_wr;
        logic                 ififo_rd;
        logic                 l0_rd;
        logic                 l0_wr;
        logic                 execute;
        logic                 load;
    } inst_fields_t;

    // Both memories disabled (active-low enables high), every strobe low.
    function automatic inst_fields_t idle_fields();
        inst_fields_t f;
        f          = '0;
        f.cen_pmem = 1'b1;
        f.wen_pmem = 1'b1;
        f.cen_xmem = 1'b1;
        f.wen_xmem = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/core_inst_sequencer_inst_pack.sv
// Combinational packer from named instruction fields to the 34-bit core packet.
module inst_pack
    import core_ctrl_pkg::*;
(
    input  inst_fields_t        fields,
    output logic [INST_W-1:0]   inst
);

    always_comb begin
        inst                                 = '0;
        inst[ACC_BIT]                        = fields.acc;
        inst[CEN_PMEM_BIT]                   = fields.cen_pmem;
        inst[WEN_PMEM_BIT]                   = fields.wen_pmem;
        inst[A_PMEM_LSB +: A_FIELD_W]        = fields.a_pmem;
        inst[CEN_XMEM_BIT]                   = fields.cen_xmem;
        inst[WEN_XMEM_BIT]                   = fields.wen_xmem;
        inst[A_XMEM_LSB +: A_FIELD_W]        = fields.a_xmem;
        inst[OFIFO_RD_BIT]                   = fields.ofifo_rd;
        inst[IFIFO_WR_BIT]                   = fields.ififo_wr;
        inst[IFIFO_RD_BIT]                   = fields.ififo_rd;
        inst[L0_RD_BIT]                      = fields.l0_rd;
        inst[L0_WR_BIT]                      = fields.l0_wr;
        inst[EXECUTE_BIT]                    = fields.execute;
        inst[LOAD_BIT]                       = fields.load;
    end

endmodule

// File: rtl/core_inst_sequencer.sv
// Drives core's instruction packets: streams weights/activations into xmem, then
// sequences L0 fill, kernel load, execute and ofifo drain into pmem.
module core_inst_sequencer
    import core_ctrl_pkg::*;
#(
    parameter int bw     = 4,
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int addr_w = 11,
    parameter int W_BASE = 0,
    parameter int A_BASE = 64,
    parameter int P_BASE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [addr_w-1:0]   n_act,
    input  logic                acc_mode,
    input  logic [bw*row-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                ofifo_valid,
    output logic [INST_W-1:0]   inst,
    output logic [bw*row-1:0]   D_xmem,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = addr_w + 1;
    localparam logic [CNT_W-1:0] COL_N     = CNT_W'(col);
    localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(col - 1);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(col + row - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [addr_w-1:0]   n_act_q, n_act_d;
    logic                acc_q, acc_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [bw*row-1:0]   d_xmem_q, d_xmem_d;

    inst_fields_t        fields;
    logic                hs;
    logic [CNT_W-1:0]    n_ext, n_last;
    logic [addr_w-1:0]   w_addr, a_addr, p_addr;

    assign hs     = in_valid & in_ready_q;
    assign n_ext  = {1'b0, n_act_q};
    assign n_last = n_ext - CNT_W'(1);
    assign w_addr = addr_w'(W_BASE) + cnt_q[addr_w-1:0];
    assign a_addr = addr_w'(A_BASE) + cnt_q[addr_w-1:0];
    assign p_addr = addr_w'(P_BASE) + cnt_q[addr_w-1:0];

    inst_pack u_pack (
        .fields (fields),
        .inst   (inst_d)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_act_d    = n_act_q;
        acc_d      = acc_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        d_xmem_d   = '0;
        fields     = idle_fields();

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = W_WR;
                    n_act_d    = n_act;
                    acc_d      = acc_mode;
                    cnt_d      = '0;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            W_WR: begin
                if (hs) begin
                    fields.cen_xmem = 1'b0;
                    fields.wen_xmem = 1'b0;
                    fields.a_xmem   = A_FIELD_W'(w_addr);
                    d_xmem_d        = in_data;
                    if (cnt_q == COL_LAST) begin
                        cnt_d = '0;
                        if (n_act_q == '0) begin
                            state_d    = W_L0;
                            in_ready_d = 1'b0;
                        end else begin
                            state_d = A_WR;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            A_WR: begin
                if (hs) begin
                    fields.cen_xmem = 1'b0;
                    fields.wen_xmem = 1'b0;
                    fields.a_xmem   = A_FIELD_W'(a_addr);
                    d_xmem_d        = in_data;
                    if (cnt_q == n_last) begin
                        cnt_d      = '0;
                        state_d    = W_L0;
                        in_ready_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            // l0_wr trails each xmem read by one cycle to cover SRAM read latency.
            W_L0: begin
                if (cnt_q < COL_N) begin
                    fields.cen_xmem = 1'b0;
                    fields.a_xmem   = A_FIELD_W'(w_addr);
                end
                fields.l0_wr = (cnt_q != '0);
                if (cnt_q == COL_N) begin
                    cnt_d   = '0;
                    state_d = W_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            W_LOAD: begin
                if (cnt_q < COL_N) begin
                    fields.l0_rd = 1'b1;
                    fields.load  = 1'b1;
                end
                if (cnt_q == LOAD_LAST) begin
                    cnt_d   = '0;
                    state_d = (n_act_q == '0) ? DONE : A_L0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            A_L0: begin
                if (cnt_q < n_ext) begin
                    fields.cen_xmem = 1'b0;
                    fields.a_xmem   = A_FIELD_W'(a_addr);
                end
                fields.l0_wr = (cnt_q != '0);
                if (cnt_q == n_ext) begin
                    cnt_d   = '0;
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EXEC: begin
                fields.l0_rd   = 1'b1;
                fields.execute = 1'b1;
                if (cnt_q == n_last) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (ofifo_valid) begin
                    fields.ofifo_rd = 1'b1;
                    fields.cen_pmem = 1'b0;
                    fields.wen_pmem = 1'b0;
                    fields.a_pmem   = A_FIELD_W'(p_addr);
                    fields.acc      = acc_q;
                    if (cnt_q == n_last) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_act_q    <= '0;
            acc_q      <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            inst_q     <= IDLE_INST;
            d_xmem_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_act_q    <= n_act_d;
            acc_q      <= acc_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            inst_q     <= inst_d;
            d_xmem_q   <= d_xmem_d;
        end
    end

    assign inst     = inst_q;
    assign D_xmem   = d_xmem_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Self-checking bench for core_inst_sequencer: per-cycle trace compared against a
// phase-level reference model, driven from a vector table plus random runs.
module tb_core_inst_sequencer;

    localparam int COL    = 8;
    localparam int ROW    = 8;
    localparam int W_BASE = 0;
    localparam int A_BASE = 64;
    localparam int P_BASE = 0;
    localparam int MAXC   = 300;
    localparam logic [33:0] IDLE_C = 34'h1800C0000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] n_act;
    logic        acc_mode;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic [31:0] D_xmem;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    logic        ivp   [MAXC+4];
    logic        ofp   [MAXC+4];
    logic [31:0] wdata [MAXC+4];
    logic [33:0] e_inst[MAXC+4];
    logic [31:0] e_dx  [MAXC+4];
    logic        e_rdy [MAXC+4];
    logic        e_busy[MAXC+4];
    logic        e_done[MAXC+4];

    typedef struct {
        int   n;
        logic acc;
        int   stall_at;
        int   stall_len;
        int   ofifo_mode;
        int   restart_at;
        int   exp_busy;
    } vec_t;

    core_inst_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .n_act       (n_act),
        .acc_mode    (acc_mode),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .D_xmem      (D_xmem),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packet builder straight from the field map: acc,CENp,WENp,Ap,CENx,WENx,Ax,ofifo_rd,0,0,l0_rd,l0_wr,exec,load.
    function automatic logic [33:0] pkt(input logic acc, input logic cenp, input logic wenp, input int ap,
                                        input logic cenx, input logic wenx, input int ax,
                                        input logic ofrd, input logic l0rd, input logic l0wr,
                                        input logic ex, input logic ld);
        logic [33:0] v;
        v = {acc, cenp, wenp, ap[10:0], cenx, wenx, ax[10:0], ofrd, 1'b0, 1'b0, l0rd, l0wr, ex, ld};
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: writes follow in_valid; everything after the last write is a fixed
    // phase list; drain consumes ofifo_valid cycles; done one cycle after the DONE cycle.
    task automatic run_model(input int n, input logic acc, output int d0, output int end_c);
        int c;
        int k;
        int p;
        int j;
        for (int i = 0; i < MAXC + 4; i++) begin
            e_inst[i] = IDLE_C;
            e_dx[i]   = '0;
            e_rdy[i]  = 1'b0;
            e_busy[i] = 1'b0;
            e_done[i] = 1'b0;
        end
        c = 0;
        k = 0;
        while (k < COL + n && c < MAXC) begin
            e_rdy[c] = 1'b1;
            if (ivp[c]) begin
                e_inst[c+1] = pkt(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0,
                                  (k < COL) ? W_BASE + k : A_BASE + k - COL,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                e_dx[c+1]   = wdata[c];
                k++;
            end
            c++;
        end
        p = c + 1;
        for (int i = 0; i <= COL; i++) begin
            e_inst[p] = pkt(1'b0, 1'b1, 1'b1, 0, (i < COL) ? 1'b0 : 1'b1, 1'b1,
                            (i < COL) ? W_BASE + i : 0, 1'b0, 1'b0, (i > 0), 1'b0, 1'b0);
            p++;
        end
        for (int i = 0; i < COL; i++) begin
            e_inst[p] = pkt(1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            p++;
        end
        p += ROW;
        if (n > 0) begin
            for (int i = 0; i <= n; i++) begin
                e_inst[p] = pkt(1'b0, 1'b1, 1'b1, 0, (i < n) ? 1'b0 : 1'b1, 1'b1,
                                (i < n) ? A_BASE + i : 0, 1'b0, 1'b0, (i > 0), 1'b0, 1'b0);
                p++;
            end
            for (int i = 0; i < n; i++) begin
                e_inst[p] = pkt(1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
                p++;
            end
        end
        d0 = p - 1;
        c  = d0;
        j  = 0;
        while (j < n && c < MAXC) begin
            if (ofp[c]) begin
                e_inst[c+1] = pkt(acc, 1'b0, 1'b0, P_BASE + j, 1'b1, 1'b1, 0,
                                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                j++;
            end
            c++;
        end
        for (int i = 0; i <= c; i++) e_busy[i] = 1'b1;
        e_done[c+1] = 1'b1;
        end_c = c + 1;
    endtask

    task automatic applyStimulus(input int n, input logic acc, input int restart_at,
                                 input string tag, output int busy_cnt);
        int d0;
        int end_c;
        run_model(n, acc, d0, end_c);
        @(negedge clk);
        start    = 1'b1;
        n_act    = 11'(n);
        acc_mode = acc;
        busy_cnt = 0;
        for (int c = 0; c <= end_c + 2; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (c == restart_at) n_act = 11'd5;
            checkOutput($sformatf("%s_c%0d", tag, c),
                        {11'b0, done, busy, in_ready, D_xmem, inst},
                        {11'b0, e_done[c], e_busy[c], e_rdy[c], e_dx[c], e_inst[c]});
            if (busy === 1'b1) busy_cnt++;
            in_valid    = ivp[c];
            in_data     = wdata[c];
            ofifo_valid = ofp[c];
        end
        in_valid    = 1'b0;
        ofifo_valid = 1'b0;
        start       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   d0;
        int   end_c;
        int   bcnt;
        int   rn;

        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        start       = 1'b0;
        n_act       = '0;
        acc_mode    = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        ofifo_valid = 1'b0;

        vecs[0] = '{n: 4, acc: 1'b1, stall_at: 0, stall_len: 0, ofifo_mode: 0, restart_at: -1, exp_busy: 51};
        vecs[1] = '{n: 0, acc: 1'b0, stall_at: 0, stall_len: 0, ofifo_mode: 0, restart_at: 15, exp_busy: 34};
        vecs[2] = '{n: 4, acc: 1'b0, stall_at: 2, stall_len: 3, ofifo_mode: 0, restart_at: -1, exp_busy: 54};
        vecs[3] = '{n: 4, acc: 1'b1, stall_at: 0, stall_len: 0, ofifo_mode: 1, restart_at: 30, exp_busy: 53};
        vecs[4] = '{n: 1, acc: 1'b1, stall_at: 0, stall_len: 0, ofifo_mode: 0, restart_at: -1, exp_busy: 39};
        vecs[5] = '{n: 3, acc: 1'b0, stall_at: 9, stall_len: 2, ofifo_mode: 1, restart_at: -1, exp_busy: 50};

        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_inst",     {46'b0, inst},     {46'b0, IDLE_C});
        checkOutput("reset_dxmem",    {48'b0, D_xmem},   80'h0);
        checkOutput("reset_in_ready", {79'b0, in_ready}, 80'h0);
        checkOutput("reset_busy",     {79'b0, busy},     80'h0);
        checkOutput("reset_done",     {79'b0, done},     80'h0);
        reset = 1'b1;

        // Abort partway through the weight writes; the next run must restart at address 0.
        @(negedge clk);
        start    = 1'b1;
        n_act    = 11'd4;
        acc_mode = 1'b0;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("midrst_inst_%0d", i),  {46'b0, inst}, {46'b0, IDLE_C});
            checkOutput($sformatf("midrst_ready_%0d", i), {78'b0, in_ready, busy}, 80'h0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            for (int c = 0; c < MAXC + 4; c++) begin
                ivp[c]   = !(vecs[v].stall_len > 0 && c >= vecs[v].stall_at &&
                             c < vecs[v].stall_at + vecs[v].stall_len);
                ofp[c]   = 1'b1;
                wdata[c] = $urandom;
            end
            if (vecs[v].ofifo_mode == 1) begin
                run_model(vecs[v].n, vecs[v].acc, d0, end_c);
                ofp[d0+1] = 1'b0;
                ofp[d0+4] = 1'b0;
            end
            applyStimulus(vecs[v].n, vecs[v].acc, vecs[v].restart_at, $sformatf("vec%0d", v), bcnt);
            checkOutput($sformatf("vec%0d_busy_cycles", v), 80'(bcnt), 80'(vecs[v].exp_busy));
        end

        for (int r = 0; r < 6; r++) begin
            rn = $urandom_range(0, 5);
            for (int c = 0; c < MAXC + 4; c++) begin
                ivp[c]   = (c >= 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
                ofp[c]   = (c >= 150) ? 1'b1 : ($urandom_range(0, 4) < 3);
                wdata[c] = $urandom;
            end
            applyStimulus(rn, 1'($urandom_range(0, 1)), -1, $sformatf("rnd%0d", r), bcnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
